// File: rtl/gmii_replay_pkg.sv
// gmii_replay_pkg: shared FSM encoding and width constants for the GMII replay block
package gmii_replay_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, GAP, DRAIN} state_e;
  localparam int WW = 9;
  localparam int PCW = 16;
endpackage

// File: rtl/gmii_replay_ram.sv
// gmii_replay_ram: simple dual-port read-first replay memory
module gmii_replay_ram
  import gmii_replay_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW = 12,
  parameter int W = 4 * WW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/gmii_replay.sv
// gmii_replay: multi-channel GMII transmit replay engine with looping, gaps and masking
module gmii_replay
  import gmii_replay_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DEPTH = 4096,
  parameter int AW = 12,
  parameter int IFGW = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NCH*WW-1:0] wr_data,
  input  logic [AW-1:0]     last_addr,
  input  logic [IFGW-1:0]   ifg_len,
  input  logic              loop_en,
  input  logic [NCH-1:0]    ch_mask,
  input  logic              start,
  input  logic              stop,
  output logic [NCH*8-1:0]  gmii_txd,
  output logic [NCH-1:0]    gmii_tx_en,
  output logic              busy,
  output logic              done,
  output logic [PCW-1:0]    pass_cnt
);
  state_e            state_q;
  logic [AW-1:0]     rd_addr_q, last_q;
  logic [IFGW-1:0]   ifg_q, gap_q;
  logic              loop_q, stop_pend_q, dcnt_q, v1_q, l1_q, busy_q, done_q;
  logic [PCW-1:0]    pass_q;
  logic [NCH*8-1:0]  txd_q, txd_d;
  logic [NCH-1:0]    en_q, en_d;
  logic [NCH*WW-1:0] rdata;
  logic              rd, at_last, cont;
  assign rd = state_q == PLAY;
  assign at_last = rd_addr_q == last_q;
  assign cont = loop_q && !(stop_pend_q || stop);
  gmii_replay_ram #(.DEPTH(DEPTH), .AW(AW), .W(NCH*WW)) u_ram (
    .clk(sys_clk), .we(wr_en), .waddr(wr_addr), .wdata(wr_data),
    .raddr(rd_addr_q), .rdata(rdata)
  );
  always_comb begin
    txd_d = '0;
    en_d = '0;
    for (int c = 0; c < NCH; c++) begin
      txd_d[8*c+:8] = (v1_q && ch_mask[c]) ? rdata[WW*c+:8] : 8'h00;
      en_d[c] = v1_q && ch_mask[c] && rdata[WW*c+8];
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      rd_addr_q <= '0;
      last_q <= '0;
      ifg_q <= '0;
      gap_q <= '0;
      loop_q <= 1'b0;
      stop_pend_q <= 1'b0;
      dcnt_q <= 1'b0;
      v1_q <= 1'b0;
      l1_q <= 1'b0;
      txd_q <= '0;
      en_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= '0;
    end else begin
      v1_q <= rd;
      l1_q <= rd && at_last;
      txd_q <= txd_d;
      en_q <= en_d;
      done_q <= 1'b0;
      if (v1_q && l1_q && pass_q != '1) pass_q <= pass_q + 1'b1;
      case (state_q)
        IDLE: if (start) begin
          state_q <= PLAY;
          rd_addr_q <= '0;
          last_q <= last_addr;
          ifg_q <= ifg_len;
          loop_q <= loop_en;
          pass_q <= '0;
          stop_pend_q <= stop;
          busy_q <= 1'b1;
        end
        PLAY: begin
          if (stop) stop_pend_q <= 1'b1;
          if (!at_last) rd_addr_q <= rd_addr_q + 1'b1;
          else if (cont) begin
            rd_addr_q <= '0;
            if (ifg_q != '0) begin
              state_q <= GAP;
              gap_q <= ifg_q - 1'b1;
            end
          end else begin
            state_q <= DRAIN;
            dcnt_q <= 1'b0;
          end
        end
        GAP: if (stop) begin
          stop_pend_q <= 1'b1;
          state_q <= DRAIN;
          dcnt_q <= 1'b0;
        end else if (gap_q == '0) begin
          state_q <= PLAY;
          rd_addr_q <= '0;
        end else gap_q <= gap_q - 1'b1;
        DRAIN: begin
          dcnt_q <= 1'b1;
          done_q <= !dcnt_q;
          if (dcnt_q) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gmii_txd = txd_q;
  assign gmii_tx_en = en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass_cnt = pass_q;
endmodule

// File: tb/tb_gmii_replay.sv
// tb_gmii_replay: directed self-checking bench for gmii_replay
module tb_gmii_replay;
  logic        clk, rst, wr_en, loop_en, start, stop, busy, done;
  logic [11:0] wr_addr, last_addr;
  logic [35:0] wr_data;
  logic [7:0]  ifg_len;
  logic [3:0]  ch_mask, gmii_tx_en;
  logic [31:0] gmii_txd;
  logic [15:0] pass_cnt;
  int n_assert = 0;
  int n_fail = 0;
  int cyc_g = 0;
  gmii_replay dut (
    .sys_clk(clk), .sys_rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_addr(last_addr), .ifg_len(ifg_len), .loop_en(loop_en), .ch_mask(ch_mask),
    .start(start), .stop(stop), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
    .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_g, obs, exp);
    end
  endtask
  function automatic logic [35:0] pat(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {1'b1, 8'hC0 + b, 1'b1, 8'h10 + b, 1'b1, 8'hA0 + b, 1'b1, 8'h55 + b};
  endfunction
  function automatic logic [31:0] expd(input logic [35:0] w, input logic [3:0] m);
    return {m[3] ? w[34:27] : 8'h00, m[2] ? w[25:18] : 8'h00,
            m[1] ? w[16:9] : 8'h00, m[0] ? w[7:0] : 8'h00};
  endfunction
  task automatic loop_run(input int last, input int ifg, input bit lp, input logic [3:0] mask,
                          input int stop_cyc, input int xs_cyc, input int npass, input int done_cyc,
                          input int wa, input logic [35:0] wd);
    int L, o, p, i, ep;
    bit act;
    logic [35:0] w;
    L = last + 1 + ifg;
    last_addr = 12'(last);
    ifg_len = 8'(ifg);
    loop_en = lp;
    ch_mask = mask;
    start = 1'b1;
    stop = (stop_cyc == 0);
    for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
      tick;
      cyc_g = cyc;
      o = cyc - 3;
      p = (o >= 0) ? o / L : 0;
      i = (o >= 0) ? o % L : 0;
      act = (o >= 0) && (p < npass) && (i <= last);
      w = (wa == i) ? wd : pat(i);
      ep = (o < last) ? 0 : (((o - last) / L + 1 < npass) ? (o - last) / L + 1 : npass);
      chk("txd", gmii_txd, act ? expd(w, mask) : 32'h0);
      chk("tx_en", gmii_tx_en, act ? (mask & {w[35], w[26], w[17], w[8]}) : 4'h0);
      chk("done", done, cyc == done_cyc);
      chk("pass_cnt", pass_cnt, 16'(ep));
      chk("busy", busy, cyc <= done_cyc);
      start = (cyc == xs_cyc);
      stop = (cyc == stop_cyc);
      wr_en = (cyc == 2) && (wa >= 0);
      wr_addr = 12'(wa);
      wr_data = wd;
    end
    start = 1'b0;
    stop = 1'b0;
    wr_en = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    last_addr = '0;
    ifg_len = '0;
    loop_en = 1'b0;
    ch_mask = 4'hF;
    start = 1'b0;
    stop = 1'b0;
    tick;
    tick;
    chk("rst_txd", gmii_txd, 32'h0);
    chk("rst_tx_en", gmii_tx_en, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass_cnt, 16'h0);
    rst = 1'b0;
    for (int a = 0; a < 4096; a++) begin
      wr_en = 1'b1;
      wr_addr = 12'(a);
      wr_data = pat(a);
      tick;
    end
    wr_en = 1'b0;
    tick;
    loop_run(7, 0, 1'b0, 4'hF, -1, 5, 1, 10, -1, 36'h0);
    loop_run(3, 0, 1'b0, 4'b0101, -1, -1, 1, 6, -1, 36'h0);
    loop_run(63, 12, 1'b1, 4'hF, 150, -1, 2, 152, -1, 36'h0);
    loop_run(63, 12, 1'b1, 4'hF, 100, -1, 2, 142, -1, 36'h0);
    loop_run(7, 0, 1'b1, 4'hF, 20, -1, 3, 26, -1, 36'h0);
    loop_run(7, 12, 1'b1, 4'hF, 0, -1, 1, 10, -1, 36'h0);
    last_addr = 12'd63;
    loop_en = 1'b0;
    ch_mask = 4'hF;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    chk("midplay_tx_en", gmii_tx_en, 4'hF);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstplay_txd", gmii_txd, 32'h0);
    chk("rstplay_tx_en", gmii_tx_en, 4'h0);
    chk("rstplay_busy", busy, 1'b0);
    chk("rstplay_pass", pass_cnt, 16'h0);
    for (int k = 0; k < 6; k++) begin
      chk("rstplay_done", done, 1'b0);
      chk("rstplay_idle", gmii_tx_en, 4'h0);
      tick;
    end
    loop_run(4095, 0, 1'b0, 4'hF, -1, -1, 1, 4098, -1, 36'h0);
    loop_run(15, 0, 1'b0, 4'hF, -1, -1, 1, 18, 10,
             {1'b1, 8'hAB, 1'b0, 8'hCD, 1'b1, 8'hEF, 1'b1, 8'h12});
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
